// File: rtl/ut_button_events_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ut_pkg
// Description : Shared types and constants for the button event unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ut_pkg;

    localparam int   BTN_COUNT   = 4;
    localparam int   BTN_IDX_W   = 2;
    localparam logic EVT_PRESS   = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

    // {kind, idx}: kind 1 = press, 0 = release
    typedef logic [BTN_IDX_W:0] evt_code_t;

    function automatic evt_code_t make_evt(input logic kind, input logic [BTN_IDX_W-1:0] idx);
        return {kind, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ut_button_events_if.sv
`default_nettype none
// ============================================================================
// Module      : ut_button_events_if
// Description : Valid/ready event port between the button unit and the MCU.
// Revision    : 1.0 - initial release
// ============================================================================
interface ut_button_events_if;
    import ut_pkg::*;

    logic      evt_valid;
    logic      evt_ready;
    evt_code_t evt_code;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface
`default_nettype wire

// File: rtl/ut_button_events_debounce.sv
`default_nettype none
// ============================================================================
// Module      : ut_debounce
// Description : Two-flop synchroniser plus stability counter for one
//               active-low button; emits a one-cycle strobe on level change.
// Revision    : 1.0 - initial release
// ============================================================================
module ut_debounce #(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_pin_n,
    output logic      o_stable,
    output logic      o_change
);

    localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_stable;
    logic               r_change;
    logic               w_sync_hi;

    assign w_sync_hi = ~r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronisers preset to the released (high) pin level
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_change <= 1'b0;
        end else begin
            r_sync1  <= i_pin_n;
            r_sync2  <= r_sync1;
            r_change <= 1'b0;
            if (w_sync_hi == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
                r_change <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_change = r_change;

endmodule
`default_nettype wire

// File: rtl/ut_button_events.sv
`default_nettype none
// ============================================================================
// Module      : ut_button_events
// Description : Debounces four active-low buttons and queues press/release
//               events in a first-word-fall-through FIFO for the probe MCU.
// Revision    : 1.0 - initial release
// ============================================================================
module ut_button_events
    import ut_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int FIFO_DEPTH      = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               but_1,
    input  wire logic               but_2,
    input  wire logic               but_3,
    input  wire logic               but_4,
    ut_button_events_if.master      evt,
    output logic [BTN_COUNT-1:0]    btn_state,
    output logic                    overflow,
    input  wire logic               clr_overflow
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [BTN_COUNT-1:0] w_pins_n;
    logic [BTN_COUNT-1:0] w_stable;
    logic [BTN_COUNT-1:0] w_change;

    logic [BTN_COUNT-1:0] r_pending;
    logic [BTN_COUNT-1:0] r_kind;
    logic                 w_arb_valid;
    logic [BTN_IDX_W-1:0] w_arb_idx;
    evt_code_t            w_push_code;

    evt_code_t            r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_overflow;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    assign w_pins_n = {but_4, but_3, but_2, but_1};

    for (genvar gi = 0; gi < BTN_COUNT; gi++) begin : g_debounce
        ut_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .i_pin_n  (w_pins_n[gi]),
            .o_stable (w_stable[gi]),
            .o_change (w_change[gi])
        );
    end

    // Lowest-index pending button wins; scanning downward lets index 0 override
    always_comb begin
        w_arb_valid = |r_pending;
        w_arb_idx   = '0;
        for (int i = BTN_COUNT - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_arb_idx = BTN_IDX_W'(i);
            end
        end
        w_push_code = make_evt(r_kind[w_arb_idx], w_arb_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_kind    <= {BTN_COUNT{EVT_RELEASE}};
        end else begin
            for (int i = 0; i < BTN_COUNT; i++) begin
                if (w_change[i]) begin
                    r_pending[i] <= 1'b1;
                    r_kind[i]    <= w_stable[i] ? EVT_PRESS : EVT_RELEASE;
                end else if (w_arb_valid && (w_arb_idx == BTN_IDX_W'(i))) begin
                    // Cleared whether the queue accepts or drops the event
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_cnt_w'(FIFO_DEPTH));
    assign w_pop   = !w_empty && evt.evt_ready;
    assign w_push  = w_arb_valid && (!w_full || w_pop);
    assign w_drop  = w_arb_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign evt.evt_valid = !w_empty;
    assign evt.evt_code  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign btn_state     = w_stable;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ut_button_events.sv
`default_nettype none
// ============================================================================
// Module      : tb_ut_button_events
// Description : Directed vector bench for ut_button_events (8-cycle debounce).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ut_button_events;
    import ut_pkg::*;

    localparam int c_deb  = 8;
    localparam int c_fifo = 4;

    typedef struct {
        logic [3:0] but_n;
        logic       ready;
        logic       clr;
        int         ticks;
        logic [3:0] exp_btn;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic       exp_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] but_n;
    logic       clr_overflow;
    logic [3:0] btn_state;
    logic       overflow;
    int         n_vec = 0;
    int         n_bad = 0;
    vec_t       vecs[$];

    ut_button_events_if evt_if ();

    ut_button_events #(
        .DEBOUNCE_CYCLES (c_deb),
        .FIFO_DEPTH      (c_fifo)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .but_1        (but_n[0]),
        .but_2        (but_n[1]),
        .but_3        (but_n[2]),
        .but_4        (but_n[3]),
        .evt          (evt_if),
        .btn_state    (btn_state),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] snap();
        return {btn_state, evt_if.evt_valid, evt_if.evt_code, overflow};
    endfunction

    // Packed as {btn_state[3:0], valid, code[2:0], overflow}
    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got btn=%b valid=%b code=%b ovf=%b, expected btn=%b valid=%b code=%b ovf=%b",
                     name, act[8:5], act[4], act[3:1], act[0], exp[8:5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] b, input logic rd, input logic clr, input int t,
                                input logic [3:0] eb, input logic ev, input logic [2:0] ec, input logic eo);
        vec_t v;
        v.but_n = b; v.ready = rd; v.clr = clr; v.ticks = t;
        v.exp_btn = eb; v.exp_valid = ev; v.exp_code = ec; v.exp_ovf = eo;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cycles;
        int extra;

        // Single press/release of but_2
        vecs.push_back(mk(4'b1101, 1, 0,  9, 4'b0000, 0, 3'b000, 0));
        vecs.push_back(mk(4'b1101, 1, 0,  1, 4'b0010, 0, 3'b000, 0));
        vecs.push_back(mk(4'b1101, 1, 0,  2, 4'b0010, 1, 3'b101, 0));
        vecs.push_back(mk(4'b1101, 1, 0,  1, 4'b0010, 0, 3'b000, 0));
        vecs.push_back(mk(4'b1101, 1, 0,  6, 4'b0010, 0, 3'b000, 0));
        vecs.push_back(mk(4'b1111, 1, 0, 10, 4'b0000, 0, 3'b000, 0));
        vecs.push_back(mk(4'b1111, 1, 0,  2, 4'b0000, 1, 3'b001, 0));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 0, 3'b000, 0));
        // but_1 glitches shorter than the debounce window
        for (int r = 0; r < 3; r++) begin
            vecs.push_back(mk(4'b1110, 1, 0, 5, 4'b0000, 0, 3'b000, 0));
            vecs.push_back(mk(4'b1111, 1, 0, 5, 4'b0000, 0, 3'b000, 0));
        end
        vecs.push_back(mk(4'b1111, 1, 0, 12, 4'b0000, 0, 3'b000, 0));
        // All four pressed together, then released together
        vecs.push_back(mk(4'b0000, 1, 0, 10, 4'b1111, 0, 3'b000, 0));
        vecs.push_back(mk(4'b0000, 1, 0,  2, 4'b1111, 1, 3'b100, 0));
        vecs.push_back(mk(4'b0000, 1, 0,  1, 4'b1111, 1, 3'b101, 0));
        vecs.push_back(mk(4'b0000, 1, 0,  1, 4'b1111, 1, 3'b110, 0));
        vecs.push_back(mk(4'b0000, 1, 0,  1, 4'b1111, 1, 3'b111, 0));
        vecs.push_back(mk(4'b0000, 1, 0,  1, 4'b1111, 0, 3'b000, 0));
        vecs.push_back(mk(4'b1111, 1, 0, 10, 4'b0000, 0, 3'b000, 0));
        vecs.push_back(mk(4'b1111, 1, 0,  2, 4'b0000, 1, 3'b000, 0));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 1, 3'b001, 0));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 1, 3'b010, 0));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 1, 3'b011, 0));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 0, 3'b000, 0));
        // Six events into a stalled queue: last two dropped
        vecs.push_back(mk(4'b1000, 0, 0, 12, 4'b0111, 1, 3'b100, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 10, 4'b0000, 1, 3'b100, 0));
        vecs.push_back(mk(4'b1111, 0, 0,  4, 4'b0000, 1, 3'b100, 1));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 1, 3'b101, 1));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 1, 3'b110, 1));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 1, 3'b000, 1));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 0, 3'b000, 1));
        vecs.push_back(mk(4'b1111, 1, 1,  1, 4'b0000, 0, 3'b000, 0));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 0, 3'b000, 0));
        // Full queue: push and pop in the same cycle keeps occupancy at 4
        vecs.push_back(mk(4'b0000, 0, 0, 12, 4'b1111, 1, 3'b100, 0));
        vecs.push_back(mk(4'b0000, 0, 0,  3, 4'b1111, 1, 3'b100, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 11, 4'b0000, 1, 3'b100, 0));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 1, 3'b101, 0));
        vecs.push_back(mk(4'b1111, 0, 0,  3, 4'b0000, 1, 3'b101, 1));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 1, 3'b110, 1));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 1, 3'b111, 1));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 1, 3'b000, 1));
        vecs.push_back(mk(4'b1111, 1, 0,  1, 4'b0000, 0, 3'b000, 1));
        vecs.push_back(mk(4'b1111, 1, 1,  1, 4'b0000, 0, 3'b000, 0));

        rst              = 1'b1;
        but_n            = 4'b1111;
        clr_overflow     = 1'b0;
        evt_if.evt_ready = 1'b1;
        tick(3);
        check("reset_state", snap(), 9'b0000_0_000_0);
        rst = 1'b0;
        tick(2);

        foreach (vecs[k]) begin
            but_n            = vecs[k].but_n;
            evt_if.evt_ready = vecs[k].ready;
            clr_overflow     = vecs[k].clr;
            tick(vecs[k].ticks);
            check($sformatf("vec%0d", k), snap(),
                  {vecs[k].exp_btn, vecs[k].exp_valid, vecs[k].exp_code, vecs[k].exp_ovf});
        end
        clr_overflow = 1'b0;

        // Reset with two events queued while but_3 stays held
        evt_if.evt_ready = 1'b0;
        but_n            = 4'b0011;
        tick(13);
        check("rst_pre_queue", snap(), 9'b1100_1_110_0);
        but_n = 4'b1011;
        rst   = 1'b1;
        tick(1);
        check("rst_flush", snap(), 9'b0000_0_000_0);
        rst              = 1'b0;
        evt_if.evt_ready = 1'b1;
        tick(c_deb + 1);
        check("rst_btn_before", snap(), 9'b0000_0_000_0);
        tick(1);
        check("rst_btn_after", snap(), 9'b0100_0_000_0);
        wait_cycles = 0;
        while (!evt_if.evt_valid && wait_cycles < 10) begin
            tick(1);
            wait_cycles++;
        end
        check_int("rst_evt_latency", wait_cycles, 2);
        check("rst_evt_code", snap(), 9'b0100_1_110_0);
        extra = 0;
        repeat (30) begin
            tick(1);
            if (evt_if.evt_valid) extra++;
        end
        check_int("rst_no_extra_evt", extra, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
